imem_loader: RTL

Boot-time writer for the 64-word instruction memory. Accepts a byte stream over a valid/ready handshake, packs little-endian bytes into 32-bit instruction words, and issues one write per word at consecutive addresses from 0. Holds the CPU in reset until a complete, well-formed image has been written. Sits between the host/debug byte source and the instruction memory's write port.

---
 rtl/imem_loader.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian byte stream (header N, then 4*N bytes) into
// 32-bit instruction-memory writes. Define LOADER_CHECKSUM_EN for a trailing checksum byte.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
  // byte_ready depends only on the current state, never on byte_valid.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK  = 3'd3,
`endif
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       shift_q, shift_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        sum_chk;
`endif
  logic              accept;
  logic              last_word;

`ifdef LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == S_HEADER) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign sum_chk    = sum_q + byte_in;
`else
  assign byte_ready = (state_q == S_HEADER) || (state_q == S_DATA);
`endif
  assign accept    = byte_valid && byte_ready;
  assign last_word = ((words_q + 1'b1) == n_q);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    addr_d     = addr_q;
    words_d    = words_q;
    lane_d     = lane_q;
    shift_d    = shift_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_HEADER;
      end
      S_HEADER: begin
        if (accept) begin
          if (byte_in == 8'h00 || byte_in > DEPTH_B) begin
            state_d    = S_ERR;
            error_d    = 1'b1;
            cpu_hold_d = 1'b1;
          end else begin
            n_d     = byte_in[ADDR_W:0];
            addr_d  = '0;
            words_d = '0;
            lane_d  = 2'd0;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = 8'h00;
`endif
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_chk;
`endif
          if (lane_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_data_d = {byte_in, shift_q};
            wr_addr_d = addr_q;
            addr_d    = addr_q + 1'b1;
            words_d   = words_q + 1'b1;
            lane_d    = 2'd0;
            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              // done and cpu release coincide with the final write strobe
              state_d    = S_DONE;
              done_d     = 1'b1;
              cpu_hold_d = 1'b0;
`endif
            end
          end else begin
            case (lane_q)
              2'd0:    shift_d[7:0]   = byte_in;
              2'd1:    shift_d[15:8]  = byte_in;
              default: shift_d[23:16] = byte_in;
            endcase
            lane_d = lane_q + 1'b1;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (sum_chk == 8'h00) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d    = S_ERR;
            error_d    = 1'b1;
            cpu_hold_d = 1'b1;
          end
        end
      end
`endif
      S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HEADER;
          done_d     = 1'b0;
          error_d    = 1'b0;
          cpu_hold_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      addr_q     <= '0;
      words_q    <= '0;
      lane_q     <= 2'd0;
      shift_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      lane_q     <= lane_d;
      shift_q    <= shift_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;
  assign dbg_state    = state_q;

endmodule
